rtc_subck_gen: RTL

RTC_SUBCK_GEN -- requirements
Module: rtc_subck_gen

---
 rtl/rtc_pkg.sv | 14 +
 rtl/rtc_pps_sync.sv | 30 +++
 rtl/rtc_subck_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared widths and helpers for the sub-second tick generator.
package rtc_pkg;

    localparam int RTC_ACC_W  = 48;
    localparam int RTC_STEP_W = 32;

    // Step that advances the accumulator by one second's worth (2^48) per CLKFREQ_HZ clocks.
    function automatic logic [RTC_STEP_W-1:0] rtc_default_step(input longint unsigned clkfreq_hz);
        longint unsigned full;
        full = (64'd1 << RTC_ACC_W) / clkfreq_hz;
        return full[RTC_STEP_W-1:0];
    endfunction

endpackage

// File: rtl/rtc_pps_sync.sv
// Two-flop synchronizer for the asynchronous GPS PPS input, followed by a
// registered rising-edge detector (three clocks from pin to o_edge).
module rtc_pps_sync
    import rtc_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_gps_pps,
    output logic o_edge
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       edge_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], i_gps_pps};
            prev_reg <= sync_reg[1];
            edge_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    assign o_edge = edge_reg;

endmodule

// File: rtl/rtc_subck_gen.sv
// Fractional-step sub-second tick and PPS generator with optional GPS re-phasing.
// Define RTC_GPS_SYNC_EN to build in the GPS synchronizer, error capture and lock tracker.
module rtc_subck_gen
    import rtc_pkg::*;
#(
    parameter int                      LGSUBCK      = 2,
    parameter longint unsigned         CLKFREQ_HZ   = 100000000,
    parameter logic [RTC_STEP_W-1:0]   DEFAULT_STEP = rtc_default_step(CLKFREQ_HZ)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_step,
    input  logic [RTC_STEP_W-1:0] i_step,
    input  logic                  i_sync_en,
    input  logic                  i_gps_pps,
    output logic                  o_sub_ck,
    output logic                  o_pps,
    output logic [RTC_STEP_W-1:0] o_step,
    output logic [31:0]           o_gps_err,
    output logic                  o_gps_locked
);

    localparam int                    SUB_BIT    = RTC_ACC_W - LGSUBCK;
    localparam logic [RTC_ACC_W:0]    STEP_LIMIT = (RTC_ACC_W+1)'(1) << SUB_BIT;
    localparam logic [RTC_STEP_W-1:0] STEP_MAX   = RTC_STEP_W'(STEP_LIMIT - 1'b1);

    logic [RTC_ACC_W-1:0]  acc_reg;
    logic [RTC_STEP_W-1:0] step_reg;
    logic [RTC_STEP_W-1:0] step_next;
    logic [RTC_ACC_W:0]    acc_ext;
    logic [RTC_ACC_W:0]    acc_sum;
    logic                  sub_carry;
    logic                  wrap;
    logic                  sub_ck_reg;
    logic                  pps_reg;
    logic                  gps_edge;
    logic                  rephase;

    // Steps are bounded below one sub-tick so at most one carry crosses SUB_BIT per clock.
    always_comb begin
        acc_ext   = {1'b0, acc_reg};
        acc_sum   = acc_ext + {{(RTC_ACC_W+1-RTC_STEP_W){1'b0}}, step_reg};
        wrap      = acc_sum[RTC_ACC_W];
        sub_carry = acc_sum[SUB_BIT] ^ acc_ext[SUB_BIT];
        step_next = i_step;
        if ({{(RTC_ACC_W+1-RTC_STEP_W){1'b0}}, i_step} >= STEP_LIMIT)
            step_next = STEP_MAX;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_reg    <= '0;
            step_reg   <= DEFAULT_STEP;
            sub_ck_reg <= 1'b0;
            pps_reg    <= 1'b0;
        end else begin
            if (rephase) begin
                acc_reg    <= '0;
                sub_ck_reg <= 1'b1;
                pps_reg    <= 1'b1;
            end else begin
                acc_reg    <= acc_sum[RTC_ACC_W-1:0];
                sub_ck_reg <= sub_carry;
                pps_reg    <= wrap;
            end
            if (i_wr_step)
                step_reg <= step_next;
        end
    end

    assign o_sub_ck = sub_ck_reg;
    assign o_pps    = pps_reg;
    assign o_step   = step_reg;

`ifdef RTC_GPS_SYNC_EN
    logic [31:0] gps_err_reg;
    logic [1:0]  miss_reg;
    logic        locked_reg;

    rtc_pps_sync u_pps_sync (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_gps_pps (i_gps_pps),
        .o_edge    (gps_edge)
    );

    assign rephase = gps_edge & i_sync_en;

    // Lock drops on the second local second that passes without a GPS edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gps_err_reg <= '0;
            miss_reg    <= 2'd0;
            locked_reg  <= 1'b0;
        end else if (gps_edge) begin
            gps_err_reg <= acc_reg[RTC_ACC_W-1:16];
            miss_reg    <= 2'd0;
            locked_reg  <= 1'b1;
        end else if (pps_reg && (miss_reg != 2'd2)) begin
            miss_reg <= miss_reg + 2'd1;
            if (miss_reg == 2'd1)
                locked_reg <= 1'b0;
        end
    end

    assign o_gps_err    = gps_err_reg;
    assign o_gps_locked = locked_reg;
`else
    logic unused_gps_inputs;

    assign unused_gps_inputs = i_gps_pps ^ i_sync_en;
    assign gps_edge          = 1'b0;
    assign rephase           = gps_edge;
    assign o_gps_err         = '0;
    assign o_gps_locked      = 1'b0;
`endif

endmodule
